// File: rtl/rvv_issue_ctrl.sv
// Scalar-side vector issue/commit controller: ID allocation, registered issue channel, commit grants,
// in-order retire and flush. Optional perf counters are enabled by defining RVV_ISSUE_CTRL_PERF_EN.
module rvv_issue_ctrl #(
  parameter int IdWidth  = 3,
  parameter int Xlen     = 64,
  parameter int CtxWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [31:0]         req_insn_i,
  input  logic [Xlen-1:0]     req_scalar_i,
  input  logic [CtxWidth-1:0] req_ctx_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [31:0]         insn_o,
  output logic [IdWidth-1:0]  insn_id_o,
  output logic [Xlen-1:0]     scalar_reg_o,
  output logic [CtxWidth-1:0] vec_context_o,
  input  logic                nonspec_i,
  output logic                insn_can_commit_o,
  output logic [IdWidth-1:0]  insn_can_commit_id_o,
  input  logic                flush_i,
  output logic                flush_o,
  input  logic                done_i,
  input  logic [IdWidth-1:0]  done_insn_id_i,
  input  logic                illegal_insn_i,
  output logic                retire_valid_o,
  input  logic                retire_ready_i,
  output logic [IdWidth-1:0]  retire_id_o,
  output logic                retire_illegal_o
`ifdef RVV_ISSUE_CTRL_PERF_EN
  ,
  output logic [31:0]         perf_issued_o,
  output logic [31:0]         perf_stall_o
`endif
);
  localparam int Depth = 1 << IdWidth;
  localparam logic [IdWidth:0] DepthCnt = (IdWidth+1)'(Depth);

  logic [IdWidth-1:0]  alloc_ptr_q, alloc_ptr_d, grant_ptr_q, grant_ptr_d, retire_ptr_q, retire_ptr_d;
  logic [IdWidth:0]    count_q, count_d;
  logic [Depth-1:0]    valid_q, valid_d, granted_q, granted_d, done_q, done_d, illegal_q, illegal_d;
  logic                issue_vld_q, commit_q, flush_q;
  logic [31:0]         insn_q;
  logic [IdWidth-1:0]  issue_id_q, commit_id_q;
  logic [Xlen-1:0]     scalar_q;
  logic [CtxWidth-1:0] ctx_q;
  logic                accept, retire_hs, retire_ungranted, grant_fire;

  assign req_ready_o      = (count_q < DepthCnt) && (!issue_vld_q || ready_i) && !flush_i;
  assign accept           = req_valid_i && req_ready_o;
  assign retire_valid_o   = valid_q[retire_ptr_q] && done_q[retire_ptr_q] &&
                            (granted_q[retire_ptr_q] || illegal_q[retire_ptr_q]);
  assign retire_id_o      = retire_ptr_q;
  assign retire_illegal_o = illegal_q[retire_ptr_q];
  assign retire_hs        = retire_valid_o && retire_ready_i;
  // An illegal entry may retire before its grant; grant_ptr then sits on it and must skip past.
  assign retire_ungranted = retire_hs && !granted_q[retire_ptr_q];
  assign grant_fire       = nonspec_i && valid_q[grant_ptr_q] && !granted_q[grant_ptr_q] &&
                            !(issue_vld_q && (issue_id_q == grant_ptr_q)) && !retire_ungranted;

  assign valid_o              = issue_vld_q;
  assign insn_o               = insn_q;
  assign insn_id_o            = issue_id_q;
  assign scalar_reg_o         = scalar_q;
  assign vec_context_o        = ctx_q;
  assign insn_can_commit_o    = commit_q;
  assign insn_can_commit_id_o = commit_id_q;
  assign flush_o              = flush_q;

  always_comb begin
    logic [IdWidth-1:0] span;
    span         = '0;
    alloc_ptr_d  = alloc_ptr_q;
    grant_ptr_d  = grant_ptr_q;
    retire_ptr_d = retire_ptr_q;
    count_d      = count_q;
    valid_d      = valid_q;
    granted_d    = granted_q;
    done_d       = done_q;
    illegal_d    = illegal_q;
    if (done_i && valid_q[done_insn_id_i]) begin
      done_d[done_insn_id_i]    = 1'b1;
      illegal_d[done_insn_id_i] = illegal_insn_i;
    end
    if (grant_fire) begin
      granted_d[grant_ptr_q] = 1'b1;
      grant_ptr_d            = grant_ptr_q + IdWidth'(1);
    end
    if (retire_hs) begin
      valid_d[retire_ptr_q]   = 1'b0;
      granted_d[retire_ptr_q] = 1'b0;
      done_d[retire_ptr_q]    = 1'b0;
      illegal_d[retire_ptr_q] = 1'b0;
      retire_ptr_d            = retire_ptr_q + IdWidth'(1);
      if (retire_ungranted) grant_ptr_d = retire_ptr_q + IdWidth'(1);
    end
    if (flush_i) begin
      valid_d     = valid_d & granted_d;
      done_d      = done_d & granted_d;
      illegal_d   = illegal_d & granted_d;
      alloc_ptr_d = grant_ptr_d;
      span        = grant_ptr_d - retire_ptr_d;
      // Equal pointers mean either empty or a table full of granted survivors.
      count_d     = ((span == '0) && valid_d[retire_ptr_d]) ? DepthCnt : {1'b0, span};
    end else begin
      if (accept) begin
        valid_d[alloc_ptr_q]   = 1'b1;
        granted_d[alloc_ptr_q] = 1'b0;
        done_d[alloc_ptr_q]    = 1'b0;
        illegal_d[alloc_ptr_q] = 1'b0;
        alloc_ptr_d            = alloc_ptr_q + IdWidth'(1);
      end
      count_d = count_q + (IdWidth+1)'(accept) - (IdWidth+1)'(retire_hs);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alloc_ptr_q  <= '0;
      grant_ptr_q  <= '0;
      retire_ptr_q <= '0;
      count_q      <= '0;
      valid_q      <= '0;
      granted_q    <= '0;
      done_q       <= '0;
      illegal_q    <= '0;
      issue_vld_q  <= 1'b0;
      insn_q       <= '0;
      issue_id_q   <= '0;
      scalar_q     <= '0;
      ctx_q        <= '0;
      commit_q     <= 1'b0;
      commit_id_q  <= '0;
      flush_q      <= 1'b0;
    end else begin
      alloc_ptr_q  <= alloc_ptr_d;
      grant_ptr_q  <= grant_ptr_d;
      retire_ptr_q <= retire_ptr_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      granted_q    <= granted_d;
      done_q       <= done_d;
      illegal_q    <= illegal_d;
      flush_q      <= flush_i;
      commit_q     <= grant_fire;
      if (grant_fire) commit_id_q <= grant_ptr_q;
      if (flush_i) begin
        issue_vld_q <= 1'b0;
      end else if (accept) begin
        issue_vld_q <= 1'b1;
        insn_q      <= req_insn_i;
        issue_id_q  <= alloc_ptr_q;
        scalar_q    <= req_scalar_i;
        ctx_q       <= req_ctx_i;
      end else if (ready_i) begin
        issue_vld_q <= 1'b0;
      end
    end
  end

`ifdef RVV_ISSUE_CTRL_PERF_EN
  logic [31:0] perf_issued_q, perf_stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (issue_vld_q && ready_i && (perf_issued_q != '1)) perf_issued_q <= perf_issued_q + 32'd1;
      if (req_valid_i && !req_ready_o && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_issued_o = perf_issued_q;
  assign perf_stall_o  = perf_stall_q;
`endif

endmodule

// File: tb/tb_rvv_issue_ctrl.sv
// Scoreboard bench for rvv_issue_ctrl: expected issues, grants and retires are queued by the stimulus
// and popped by a negedge monitor; directed checks cover latency, full, hold, flush and ordering cases.
module tb_rvv_issue_ctrl;
  localparam int IdW = 3;
  localparam int XL  = 64;
  localparam int CW  = 16;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic           req_valid_i, req_ready_o;
  logic [31:0]    req_insn_i;
  logic [XL-1:0]  req_scalar_i;
  logic [CW-1:0]  req_ctx_i;
  logic           valid_o, ready_i;
  logic [31:0]    insn_o;
  logic [IdW-1:0] insn_id_o;
  logic [XL-1:0]  scalar_reg_o;
  logic [CW-1:0]  vec_context_o;
  logic           nonspec_i, insn_can_commit_o;
  logic [IdW-1:0] insn_can_commit_id_o;
  logic           flush_i, flush_o;
  logic           done_i, illegal_insn_i;
  logic [IdW-1:0] done_insn_id_i;
  logic           retire_valid_o, retire_ready_i, retire_illegal_o;
  logic [IdW-1:0] retire_id_o;
`ifdef RVV_ISSUE_CTRL_PERF_EN
  logic [31:0]    perf_issued_o, perf_stall_o;
`endif

  rvv_issue_ctrl #(.IdWidth(IdW), .Xlen(XL), .CtxWidth(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_insn_i(req_insn_i),
    .req_scalar_i(req_scalar_i), .req_ctx_i(req_ctx_i),
    .valid_o(valid_o), .ready_i(ready_i), .insn_o(insn_o), .insn_id_o(insn_id_o),
    .scalar_reg_o(scalar_reg_o), .vec_context_o(vec_context_o),
    .nonspec_i(nonspec_i), .insn_can_commit_o(insn_can_commit_o),
    .insn_can_commit_id_o(insn_can_commit_id_o),
    .flush_i(flush_i), .flush_o(flush_o),
    .done_i(done_i), .done_insn_id_i(done_insn_id_i), .illegal_insn_i(illegal_insn_i),
    .retire_valid_o(retire_valid_o), .retire_ready_i(retire_ready_i),
    .retire_id_o(retire_id_o), .retire_illegal_o(retire_illegal_o)
`ifdef RVV_ISSUE_CTRL_PERF_EN
    , .perf_issued_o(perf_issued_o), .perf_stall_o(perf_stall_o)
`endif
  );

  typedef struct packed {
    logic [31:0]    insn;
    logic [IdW-1:0] id;
    logic [XL-1:0]  sc;
    logic [CW-1:0]  ctx;
  } iss_t;
  typedef struct packed {
    logic [IdW-1:0] id;
    logic           ill;
  } ret_t;

  iss_t           exp_iss[$];
  logic [IdW-1:0] exp_grant[$];
  ret_t           exp_ret[$];
  iss_t           e_iss;
  logic [IdW-1:0] e_grant;
  ret_t           e_ret;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (valid_o && ready_i) begin
        chk("issue_expected", exp_iss.size() != 0, 1);
        if (exp_iss.size() != 0) begin
          e_iss = exp_iss.pop_front();
          chk("issue_payload", {insn_o, insn_id_o, scalar_reg_o, vec_context_o}, e_iss);
        end
      end
      if (insn_can_commit_o) begin
        chk("grant_expected", exp_grant.size() != 0, 1);
        if (exp_grant.size() != 0) begin
          e_grant = exp_grant.pop_front();
          chk("grant_id", insn_can_commit_id_o, e_grant);
        end
      end
      if (retire_valid_o && retire_ready_i) begin
        chk("retire_expected", exp_ret.size() != 0, 1);
        if (exp_ret.size() != 0) begin
          e_ret = exp_ret.pop_front();
          chk("retire_fields", {retire_id_o, retire_illegal_o}, e_ret);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid_i = 0; req_insn_i = '0; req_scalar_i = '0; req_ctx_i = '0;
    ready_i = 1; nonspec_i = 0; flush_i = 0;
    done_i = 0; done_insn_id_i = '0; illegal_insn_i = 0; retire_ready_i = 1;
  endtask

  task automatic do_reset();
    ready_i = 1; retire_ready_i = 1; req_valid_i = 0; nonspec_i = 0; flush_i = 0; done_i = 0;
    repeat (3) tick();
    chk("drain_issue", exp_iss.size(), 0);
    chk("drain_grant", exp_grant.size(), 0);
    chk("drain_retire", exp_ret.size(), 0);
    rst_ni = 0;
    idle_inputs();
    #1;
    chk("reset_outputs", {valid_o, insn_can_commit_o, flush_o, retire_valid_o, insn_id_o, retire_id_o}, 0);
    repeat (2) tick();
    rst_ni = 1;
    tick();
  endtask

  task automatic accept_req(input logic [31:0] insn, input logic [XL-1:0] sc,
                            input logic [CW-1:0] ctx, input logic [IdW-1:0] id);
    int n;
    req_valid_i = 1; req_insn_i = insn; req_scalar_i = sc; req_ctx_i = ctx;
    #1;
    n = 0;
    while (!req_ready_o && n < 16) begin
      @(posedge clk_i);
      #2;
      n++;
    end
    chk("accept_within_bound", req_ready_o, 1);
    exp_iss.push_back('{insn: insn, id: id, sc: sc, ctx: ctx});
    @(posedge clk_i);
    #1;
    req_valid_i = 0;
  endtask

  task automatic nonspec(input bit fire, input logic [IdW-1:0] id);
    nonspec_i = 1;
    if (fire) exp_grant.push_back(id);
    tick();
    nonspec_i = 0;
  endtask

  task automatic send_done(input logic [IdW-1:0] id, input logic ill);
    done_i = 1; done_insn_id_i = id; illegal_insn_i = ill;
    tick();
    done_i = 0; illegal_insn_i = 0;
  endtask

  initial begin
    rst_ni = 0;
    idle_inputs();
    do_reset();
    chk("empty_ready", req_ready_o, 1);

    // Single instruction end to end.
    accept_req(32'h0000_0057, 64'h1234, 16'h00a5, 3'd0);
    chk("issue_latency", {valid_o, insn_id_o}, {1'b1, 3'd0});
    tick();
    nonspec(1, 3'd0);
    exp_ret.push_back('{id: 3'd0, ill: 1'b0});
    send_done(3'd0, 1'b0);
    chk("single_retire", {retire_valid_o, retire_id_o, retire_illegal_o}, {1'b1, 3'd0, 1'b0});
    tick();
    chk("single_retired", retire_valid_o, 0);

    // Fill the table, then retire and request in the same cycle.
    do_reset();
    retire_ready_i = 0;
    for (int i = 0; i < 8; i++) begin
      chk("fill_ready", req_ready_o, 1);
      accept_req(32'h1000_0000 + i, 64'(i) << 8, 16'(i), 3'(i));
    end
    req_valid_i = 1; req_insn_i = 32'hdead_0057; req_scalar_i = 64'h99; req_ctx_i = 16'h77;
    #1;
    chk("full_ready", req_ready_o, 0);
    tick();
    nonspec(1, 3'd0);
    send_done(3'd0, 1'b0);
    retire_ready_i = 1;
    exp_ret.push_back('{id: 3'd0, ill: 1'b0});
    #1;
    chk("full_retire_valid", retire_valid_o, 1);
    chk("full_retire_noaccept", req_ready_o, 0);
    tick();
    chk("after_retire_ready", req_ready_o, 1);
    exp_iss.push_back('{insn: 32'hdead_0057, id: 3'd0, sc: 64'h99, ctx: 16'h77});
    tick();
    req_valid_i = 0;

    // Backpressure: payload held while ready_i is low; grant dropped while entry is in the output register.
    do_reset();
    ready_i = 0;
    accept_req(32'haaaa_0057, 64'h1111, 16'h0101, 3'd0);
    req_valid_i = 1; req_insn_i = 32'hbbbb_0057; req_scalar_i = 64'h2222; req_ctx_i = 16'h0202;
    for (int k = 0; k < 5; k++) begin
      nonspec_i = (k == 2);
      #1;
      chk("hold_payload", {valid_o, insn_o, insn_id_o, scalar_reg_o, vec_context_o},
          {1'b1, 32'haaaa_0057, 3'd0, 64'h1111, 16'h0101});
      chk("hold_ready", req_ready_o, 0);
      @(posedge clk_i);
      #1;
      nonspec_i = 0;
    end
    ready_i = 1;
    exp_iss.push_back('{insn: 32'hbbbb_0057, id: 3'd1, sc: 64'h2222, ctx: 16'h0202});
    #1;
    chk("release_ready", req_ready_o, 1);
    @(posedge clk_i);
    #1;
    req_valid_i = 0;
    tick();
    nonspec(1, 3'd0);
    nonspec(1, 3'd1);
    exp_ret.push_back('{id: 3'd0, ill: 1'b0});
    exp_ret.push_back('{id: 3'd1, ill: 1'b0});
    send_done(3'd0, 1'b0);
    send_done(3'd1, 1'b0);

    // Flush with a same-cycle grant; late done for a flushed ID.
    do_reset();
    for (int i = 0; i < 4; i++) accept_req(32'h2000_0057 + (i << 12), 64'(i), 16'(i), 3'(i));
    tick();
    nonspec(1, 3'd0);
    nonspec_i = 1; flush_i = 1;
    exp_grant.push_back(3'd1);
    req_valid_i = 1; req_insn_i = 32'hcccc_0057; req_scalar_i = 64'h3333; req_ctx_i = 16'h0303;
    #1;
    chk("flush_noaccept", req_ready_o, 0);
    tick();
    nonspec_i = 0; flush_i = 0;
    chk("flush_pulse", {flush_o, valid_o}, {1'b1, 1'b0});
    done_i = 1; done_insn_id_i = 3'd3; illegal_insn_i = 1;
    exp_iss.push_back('{insn: 32'hcccc_0057, id: 3'd2, sc: 64'h3333, ctx: 16'h0303});
    #1;
    chk("post_flush_ready", req_ready_o, 1);
    tick();
    req_valid_i = 0; done_i = 0; illegal_insn_i = 0;
    chk("flush_pulse_end", flush_o, 0);
    exp_ret.push_back('{id: 3'd0, ill: 1'b0});
    exp_ret.push_back('{id: 3'd1, ill: 1'b0});
    send_done(3'd0, 1'b0);
    send_done(3'd1, 1'b0);
    nonspec(1, 3'd2);
    exp_ret.push_back('{id: 3'd2, ill: 1'b0});
    send_done(3'd2, 1'b0);
    tick();
    chk("flushed_id3_not_retiring", retire_valid_o, 0);

    // Illegal completion before grant.
    do_reset();
    accept_req(32'h0000_0057, 64'h5, 16'h5, 3'd0);
    tick();
    exp_ret.push_back('{id: 3'd0, ill: 1'b1});
    send_done(3'd0, 1'b1);
    chk("illegal_retire", {retire_valid_o, retire_id_o, retire_illegal_o}, {1'b1, 3'd0, 1'b1});
    tick();
    chk("illegal_retired", retire_valid_o, 0);
    accept_req(32'h0000_1057, 64'h6, 16'h6, 3'd1);
    tick();
    nonspec(1, 3'd1);
    exp_ret.push_back('{id: 3'd1, ill: 1'b0});
    send_done(3'd1, 1'b0);

    // Out-of-order completion, in-order retire.
    do_reset();
    accept_req(32'h4000_0057, 64'h40, 16'h40, 3'd0);
    accept_req(32'h4100_0057, 64'h41, 16'h41, 3'd1);
    tick();
    nonspec(1, 3'd0);
    nonspec(1, 3'd1);
    send_done(3'd1, 1'b0);
    chk("ooo_wait", retire_valid_o, 0);
    exp_ret.push_back('{id: 3'd0, ill: 1'b0});
    exp_ret.push_back('{id: 3'd1, ill: 1'b0});
    send_done(3'd0, 1'b0);
    chk("ooo_first", {retire_valid_o, retire_id_o}, {1'b1, 3'd0});
    tick();
    chk("ooo_second", {retire_valid_o, retire_id_o}, {1'b1, 3'd1});
    tick();
    chk("ooo_empty", retire_valid_o, 0);

    repeat (4) tick();
    chk("final_issue_queue", exp_iss.size(), 0);
    chk("final_grant_queue", exp_grant.size(), 0);
    chk("final_retire_queue", exp_ret.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
